// File: rtl/vga_sync_decoder_if.sv
// VGA sync decoder bus: raw sync/blank inputs and recovered timing outputs.
// master drives the video stream, slave is the decoder.
`timescale 1ns/1ps

interface vga_sync_decoder_if;
    logic       pixel_clk;
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] RxX;
    logic [9:0] RxY;
    logic       pixel_valid;
    logic       frame_start;
    logic       locked;
    logic [9:0] line_len;
    logic [9:0] frame_lines;
    logic       err_hsync;
    logic       err_vsync;

    modport master (
        output pixel_clk, hs, vs, blank,
        input  RxX, RxY, pixel_valid, frame_start, locked,
        input  line_len, frame_lines, err_hsync, err_vsync
    );

    modport slave (
        input  pixel_clk, hs, vs, blank,
        output RxX, RxY, pixel_valid, frame_start, locked,
        output line_len, frame_lines, err_hsync, err_vsync
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hs/vs/blank, measures
// line and frame periods, and tracks timing lock over consecutive frames.
`timescale 1ns/1ps

module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input logic          Clk,
    input logic          Reset,
    vga_sync_decoder_if.slave bus
);
    localparam logic [9:0] SAT = 10'd1023;
    localparam logic [9:0] HT  = 10'(H_TOTAL);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [7:0] LF  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t     state_q;
    logic [7:0] good_q;
    logic       err_seen_q, locked_q;

    logic       pclk_q, hs_q, vs_q, act_q, harm_q, varm_q;
    logic       pclk_d, hs_d, vs_d, act_d, harm_d, varm_d;
    logic [9:0] hcnt_q, lcnt_q, xcnt_q, ycnt_q;
    logic [9:0] hcnt_d, lcnt_d, xcnt_d, ycnt_d;
    logic [9:0] rx_q, ry_q, len_q, fl_q;
    logic [9:0] rx_d, ry_d, len_d, fl_d;
    logic       pv_q, fs_q, eh_q, ev_q;
    logic       pv_d, fs_d, eh_d, ev_d;

    logic       tick, hs_fall, vs_fall;
    logic       herr, wdog, verr, any_err, enter_search;
    logic [9:0] len_new, fl_new;

    // Tick/edge detection and error conditions for the current tick
    always_comb begin
        tick         = bus.pixel_clk & ~pclk_q;
        hs_fall      = tick & hs_q & ~bus.hs;
        vs_fall      = tick & vs_q & ~bus.vs;
        len_new      = (hcnt_q == SAT) ? SAT : hcnt_q + 10'd1;
        fl_new       = (hs_fall && lcnt_q != SAT) ? lcnt_q + 10'd1 : lcnt_q;
        herr         = hs_fall & harm_q & (len_new != HT);
        wdog         = tick & ~hs_fall & (hcnt_q == SAT - 10'd1);
        verr         = vs_fall & varm_q & (fl_new != VT);
        any_err      = herr | wdog | verr;
        enter_search = (state_q == LOCKED) & any_err;
    end

    // Next-state for counters, coordinate capture and measurements
    always_comb begin
        pclk_d = bus.pixel_clk;
        hs_d   = hs_q;
        vs_d   = vs_q;
        hcnt_d = hcnt_q;
        lcnt_d = lcnt_q;
        xcnt_d = xcnt_q;
        ycnt_d = ycnt_q;
        act_d  = act_q;
        harm_d = harm_q;
        varm_d = varm_q;
        rx_d   = rx_q;
        ry_d   = ry_q;
        len_d  = len_q;
        fl_d   = fl_q;
        pv_d   = 1'b0;
        fs_d   = 1'b0;
        eh_d   = 1'b0;
        ev_d   = 1'b0;
        if (tick) begin
            hs_d = bus.hs;
            vs_d = bus.vs;
            if (hs_fall)
                hcnt_d = '0;
            else if (hcnt_q != SAT)
                hcnt_d = hcnt_q + 10'd1;
            if (hs_fall) begin
                harm_d = 1'b1;
                if (harm_q)
                    len_d = len_new;
            end
            eh_d   = herr | wdog;
            lcnt_d = vs_fall ? '0 : fl_new;
            if (vs_fall) begin
                fl_d   = fl_new;
                fs_d   = 1'b1;
                varm_d = 1'b1;
            end
            ev_d = verr;
            if (bus.blank) begin
                rx_d   = xcnt_q;
                ry_d   = ycnt_q;
                pv_d   = 1'b1;
                xcnt_d = xcnt_q + 10'd1;
            end else begin
                xcnt_d = '0;
            end
            act_d = act_q | bus.blank;
            if (hs_fall && act_q) begin
                ycnt_d = (ycnt_q == SAT) ? SAT : ycnt_q + 10'd1;
                act_d  = bus.blank;
            end
            if (vs_fall) begin
                ycnt_d = '0;
                act_d  = 1'b0;
            end
            if (enter_search) begin
                harm_d = 1'b0;
                varm_d = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pclk_q <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            hcnt_q <= '0;
            lcnt_q <= '0;
            xcnt_q <= '0;
            ycnt_q <= '0;
            act_q  <= 1'b0;
            harm_q <= 1'b0;
            varm_q <= 1'b0;
            rx_q   <= '0;
            ry_q   <= '0;
            len_q  <= '0;
            fl_q   <= '0;
            pv_q   <= 1'b0;
            fs_q   <= 1'b0;
            eh_q   <= 1'b0;
            ev_q   <= 1'b0;
        end else begin
            pclk_q <= pclk_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            hcnt_q <= hcnt_d;
            lcnt_q <= lcnt_d;
            xcnt_q <= xcnt_d;
            ycnt_q <= ycnt_d;
            act_q  <= act_d;
            harm_q <= harm_d;
            varm_q <= varm_d;
            rx_q   <= rx_d;
            ry_q   <= ry_d;
            len_q  <= len_d;
            fl_q   <= fl_d;
            pv_q   <= pv_d;
            fs_q   <= fs_d;
            eh_q   <= eh_d;
            ev_q   <= ev_d;
        end
    end

    // Lock FSM: counts clean frames between vs edges, drops on any error
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= SEARCH;
            good_q     <= '0;
            err_seen_q <= 1'b0;
            locked_q   <= 1'b0;
        end else if (tick) begin
            unique case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_q    <= ACQUIRE;
                        good_q     <= '0;
                        err_seen_q <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (vs_fall) begin
                        err_seen_q <= 1'b0;
                        if (err_seen_q || any_err) begin
                            good_q <= '0;
                        end else if (good_q + 8'd1 == LF) begin
                            good_q   <= '0;
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            good_q <= good_q + 8'd1;
                        end
                    end else if (any_err) begin
                        err_seen_q <= 1'b1;
                        good_q     <= '0;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RxX         = rx_q;
    assign bus.RxY         = ry_q;
    assign bus.pixel_valid = pv_q;
    assign bus.frame_start = fs_q;
    assign bus.locked      = locked_q;
    assign bus.line_len    = len_q;
    assign bus.frame_lines = fl_q;
    assign bus.err_hsync   = eh_q;
    assign bus.err_vsync   = ev_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 40x20 raster (24x12 active)
// so that many frames, the 1023-tick watchdog and reset fit quickly.
`timescale 1ns/1ps

module tb_vga_sync_decoder;
    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HA  = 24;
    localparam int VA  = 12;
    localparam int HS0 = 28;
    localparam int HS1 = 32;
    localparam int VS0 = 14;
    localparam int NR  = 14;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pix_t;

    typedef struct {
        int nl;
        int longl;
        int e_len;
        int e_fl;
        int e_eh;
        int e_ev;
        int e_lk;
    } row_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #10 Clk = ~Clk;

    vga_sync_decoder_if vif();

    vga_sync_decoder #(
        .H_TOTAL(HT),
        .V_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(vif)
    );

    pix_t sbq[$];
    pix_t mon_e;
    int n_cmp = 0;
    int n_bad = 0;
    int n_pix = 0;
    int n_errh = 0;
    int n_errv = 0;
    int n_fs = 0;
    int tick_no = 0;
    int last_hfall = 0;
    int errh_tick = 0;
    int errh_len = 0;
    int errv_fl = 0;
    logic lk_prev = 1'b0;
    logic lock_rise_fs = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rxx"}, vif.RxX, 0);
        check({tag, "_rxy"}, vif.RxY, 0);
        check({tag, "_pv"}, vif.pixel_valid, 0);
        check({tag, "_fs"}, vif.frame_start, 0);
        check({tag, "_lock"}, vif.locked, 0);
        check({tag, "_len"}, vif.line_len, 0);
        check({tag, "_fl"}, vif.frame_lines, 0);
        check({tag, "_eh"}, vif.err_hsync, 0);
        check({tag, "_ev"}, vif.err_vsync, 0);
    endtask

    function automatic logic hs_at(input int x);
        return !(x >= HS0 && x < HS1);
    endfunction

    function automatic logic vs_at(input int y);
        return !(y >= VS0 && y < VS0 + 2);
    endfunction

    function automatic logic bl_at(input int x, input int y);
        return (x < HA) && (y < VA);
    endfunction

    task automatic do_tick(input logic h, input logic v, input logic b,
                           input int x, input int y);
        pix_t e;
        @(negedge Clk);
        tick_no++;
        if (vif.hs && !h)
            last_hfall = tick_no;
        vif.pixel_clk = 1'b1;
        vif.hs = h;
        vif.vs = v;
        vif.blank = b;
        if (b) begin
            e.x = 10'(x);
            e.y = 10'(y);
            sbq.push_back(e);
        end
        @(negedge Clk);
        vif.pixel_clk = 1'b0;
        #1;
    endtask

    task automatic run_frame(input int nl, input int longl);
        for (int y = 0; y < nl; y++) begin
            int len;
            len = (y == longl) ? HT + 1 : HT;
            for (int x = 0; x < len; x++)
                do_tick(hs_at(x), vs_at(y), bl_at(x, y), x, y);
        end
    endtask

    always @(negedge Clk) begin
        if (vif.pixel_valid) begin
            n_pix++;
            check("pix_q_nonempty", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                check("pix_x", vif.RxX, mon_e.x);
                check("pix_y", vif.RxY, mon_e.y);
            end
        end
        if (vif.err_hsync) begin
            n_errh++;
            errh_tick = tick_no;
            errh_len = vif.line_len;
        end
        if (vif.err_vsync) begin
            n_errv++;
            errv_fl = vif.frame_lines;
        end
        if (vif.frame_start)
            n_fs++;
        if (vif.locked && !lk_prev)
            lock_rise_fs = vif.frame_start;
        lk_prev = vif.locked;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: run did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        row_t tbl[NR];
        int eh0, ev0, fs0, px0, hold_l;

        tbl[0]  = '{20, -1, 40, 14, 0, 0, 0};
        tbl[1]  = '{20, -1, 40, 20, 0, 0, 0};
        tbl[2]  = '{20, -1, 40, 20, 0, 0, 1};
        tbl[3]  = '{20, -1, 40, 20, 0, 0, 1};
        tbl[4]  = '{20,  5, 40, 20, 1, 0, 0};
        tbl[5]  = '{20, -1, 40, 20, 0, 0, 0};
        tbl[6]  = '{20, -1, 40, 20, 0, 0, 1};
        tbl[7]  = '{19, -1, 40, 20, 0, 0, 1};
        tbl[8]  = '{20, -1, 40, 19, 0, 1, 0};
        tbl[9]  = '{20, -1, 40, 20, 0, 0, 0};
        tbl[10] = '{19, -1, 40, 20, 0, 0, 0};
        tbl[11] = '{20, -1, 40, 19, 0, 1, 0};
        tbl[12] = '{20, -1, 40, 20, 0, 0, 0};
        tbl[13] = '{20, -1, 40, 20, 0, 0, 1};

        vif.pixel_clk = 1'b0;
        vif.hs = 1'b0;
        vif.vs = 1'b0;
        vif.blank = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        check_all_zero("post_reset");

        for (int r = 0; r < NR; r++) begin
            eh0 = n_errh;
            ev0 = n_errv;
            fs0 = n_fs;
            px0 = n_pix;
            run_frame(tbl[r].nl, tbl[r].longl);
            check($sformatf("r%0d_len", r), vif.line_len, tbl[r].e_len);
            check($sformatf("r%0d_fl", r), vif.frame_lines, tbl[r].e_fl);
            check($sformatf("r%0d_errh", r), n_errh - eh0, tbl[r].e_eh);
            check($sformatf("r%0d_errv", r), n_errv - ev0, tbl[r].e_ev);
            check($sformatf("r%0d_fs", r), n_fs - fs0, 1);
            check($sformatf("r%0d_lock", r), vif.locked, tbl[r].e_lk);
            check($sformatf("r%0d_pix", r), n_pix - px0, HA * VA);
            if (r == 2)
                check("lock_with_3rd_fs", lock_rise_fs, 1);
            if (r == 4)
                check("long_line_len", errh_len, HT + 1);
            if (r == 8)
                check("short_frame_fl", errv_fl, VT - 1);
        end

        eh0 = n_errh;
        hold_l = last_hfall;
        repeat (1100) do_tick(1'b1, 1'b1, 1'b0, 0, 0);
        check("wdog_count", n_errh - eh0, 1);
        check("wdog_delay", errh_tick - hold_l, 1023);
        check("wdog_len", vif.line_len, HT);
        check("wdog_lock", vif.locked, 0);

        for (int t = 0; t < HT + 11; t++)
            do_tick(hs_at(t % HT), 1'b1, bl_at(t % HT, t / HT), t % HT, t / HT);
        check("pre_rst_rxx", vif.RxX, 10);
        check("pre_rst_rxy", vif.RxY, 1);
        check("pre_rst_len", vif.line_len, HT);
        Reset = 1'b1;
        #1;
        check_all_zero("mid_rst");
        check("mid_rst_queue", sbq.size(), 0);
        vif.hs = 1'b0;
        vif.vs = 1'b0;
        vif.blank = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        fs0 = n_fs;
        repeat (20) do_tick(1'b0, 1'b0, 1'b0, 0, 0);
        check("no_false_fs", n_fs - fs0, 0);
        do_tick(1'b1, 1'b1, 1'b0, 0, 0);
        do_tick(1'b0, 1'b0, 1'b0, 0, 0);
        check("genuine_fs", n_fs - fs0, 1);

        ev0 = n_errv;
        run_frame(VT, -1);
        check("relock_a_errv", n_errv - ev0, 1);
        check("relock_a_lock", vif.locked, 0);
        run_frame(VT, -1);
        check("relock_b_lock", vif.locked, 0);
        run_frame(VT, -1);
        check("relock_c_lock", vif.locked, 1);
        check("final_queue", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
